// File: rtl/led_seq_pkg.sv
// ---------------------------------------------------------------------------
// led_seq_pkg
// Shared definitions for the LED pattern sequencer.
//   mode_e : run-time pattern selection (rotate-left, rotate-right,
//            ping-pong, blink-all)
//   PWM_W  : width of the dimming counter and duty value used when the
//            design is built with LED_SEQ_DIM_EN
// No ports (package).
// ---------------------------------------------------------------------------
package led_seq_pkg;

  typedef enum logic [1:0] {
    MODE_ROTL  = 2'd0,
    MODE_ROTR  = 2'd1,
    MODE_PING  = 2'd2,
    MODE_BLINK = 2'd3
  } mode_e;

  localparam int PWM_W = 8;

endpackage : led_seq_pkg

// File: rtl/led_seq_if.sv
// ---------------------------------------------------------------------------
// led_seq_if
// Bundles the sequencer's control inputs and LED outputs.
//   tick_in  : one-cycle step pulse from the period counter
//   run      : 1 = step on tick_in, 0 = hold pattern
//   mode     : pattern selection (see led_seq_pkg::mode_e)
//   duty     : PWM duty, only present when LED_SEQ_DIM_EN is defined
//   led_out  : LED drive, 1 = lit
//   wrap_out : one-cycle pulse when the pattern returns to its start value
// Modports: master drives the controls, slave is the sequencer.
// ---------------------------------------------------------------------------
interface led_seq_if #(
  parameter int LED_W = 4
);

  logic                            tick_in;
  logic                            run;
  logic [1:0]                      mode;
`ifdef LED_SEQ_DIM_EN
  logic [led_seq_pkg::PWM_W-1:0]   duty;
`endif
  logic [LED_W-1:0]                led_out;
  logic                            wrap_out;

`ifdef LED_SEQ_DIM_EN
  modport master (
    output tick_in, run, mode, duty,
    input  led_out, wrap_out
  );

  modport slave (
    input  tick_in, run, mode, duty,
    output led_out, wrap_out
  );
`else
  modport master (
    output tick_in, run, mode,
    input  led_out, wrap_out
  );

  modport slave (
    input  tick_in, run, mode,
    output led_out, wrap_out
  );
`endif

endinterface : led_seq_if

// File: rtl/led_pwm_gen.sv
// ---------------------------------------------------------------------------
// led_pwm_gen
// Free-running 8-bit PWM counter plus duty compare. Only instantiated by
// led_seq when LED_SEQ_DIM_EN is defined.
//   sys_clk   : system clock
//   sys_rst_n : asynchronous active-low reset
//   duty      : number of cycles out of every 256 the mask is high
//   mask      : 1 while the counter is below duty
// ---------------------------------------------------------------------------
module led_pwm_gen
  import led_seq_pkg::*;
(
  input  logic             sys_clk,
  input  logic             sys_rst_n,
  input  logic [PWM_W-1:0] duty,
  output logic             mask
);

  logic [PWM_W-1:0] pwm_cnt;

  // Counter wraps naturally from 255 back to 0.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      pwm_cnt <= '0;
    end else begin
      pwm_cnt <= pwm_cnt + 1'b1;
    end
  end

  // duty = 0 never lights; duty = 255 leaves only count 255 dark.
  assign mask = (pwm_cnt < duty);

endmodule : led_pwm_gen

// File: rtl/led_seq.sv
// ---------------------------------------------------------------------------
// led_seq
// LED pattern sequencer. Steps a LED_W-wide pattern once per tick_in while
// run is high, in one of four run-time selectable modes, and pulses
// wrap_out when a step brings the pattern back to the mode's start value.
//   sys_clk   : system clock
//   sys_rst_n : asynchronous active-low reset
//   bus       : led_seq_if slave (tick_in, run, mode, [duty], led_out,
//               wrap_out)
// Optional feature: define LED_SEQ_DIM_EN to add PWM dimming. led_out then
// becomes a register of led_state gated by the PWM mask (one extra cycle
// of latency); wrap_out timing is unchanged.
// ---------------------------------------------------------------------------
module led_seq
  import led_seq_pkg::*;
#(
  parameter int LED_W = 4
) (
  input  logic      sys_clk,
  input  logic      sys_rst_n,
  led_seq_if.slave  bus
);

  logic [LED_W-1:0] led_state;
  mode_e            mode_q;
  logic             dir;
  logic             wrap_q;

  mode_e            mode_new;
  logic [LED_W-1:0] start_new;
  logic [LED_W-1:0] start_cur;
  logic [LED_W-1:0] step_next;
  logic             dir_next;
  logic             step_wrap;

  // Start value of each mode; ping-pong also starts with dir = 0.
  function automatic logic [LED_W-1:0] start_of(mode_e m);
    logic [LED_W-1:0] pat;
    case (m)
      MODE_ROTR:  pat = LED_W'(1) << (LED_W - 1);
      MODE_BLINK: pat = '1;
      default:    pat = LED_W'(1);
    endcase
    return pat;
  endfunction

  // Next pattern if a step happens this cycle, and whether that step lands
  // on the start value. Ping-pong turns around in the same step that
  // reaches an end LED, so the wrap only counts once the direction has
  // flipped back toward the MSB.
  always_comb begin
    mode_new  = mode_e'(bus.mode);
    start_new = start_of(mode_new);
    start_cur = start_of(mode_q);
    step_next = led_state;
    dir_next  = dir;
    case (mode_q)
      MODE_ROTL: step_next = {led_state[LED_W-2:0], led_state[LED_W-1]};
      MODE_ROTR: step_next = {led_state[0], led_state[LED_W-1:1]};
      MODE_PING: begin
        if (!dir) begin
          step_next = led_state << 1;
          dir_next  = step_next[LED_W-1];
        end else begin
          step_next = led_state >> 1;
          dir_next  = ~step_next[0];
        end
      end
      MODE_BLINK: step_next = ~led_state;
      default:    step_next = led_state;
    endcase
    step_wrap = (step_next == start_cur) && ((mode_q != MODE_PING) || !dir_next);
  end

  // Pattern state machine. A mode change always takes priority over a tick
  // and reloads the new mode's start value without a wrap pulse.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      led_state <= LED_W'(1);
      mode_q    <= MODE_ROTL;
      dir       <= 1'b0;
      wrap_q    <= 1'b0;
    end else if (mode_new != mode_q) begin
      led_state <= start_new;
      mode_q    <= mode_new;
      dir       <= 1'b0;
      wrap_q    <= 1'b0;
    end else if (bus.run && bus.tick_in) begin
      led_state <= step_next;
      dir       <= dir_next;
      wrap_q    <= step_wrap;
    end else begin
      wrap_q    <= 1'b0;
    end
  end

  assign bus.wrap_out = wrap_q;

`ifdef LED_SEQ_DIM_EN
  logic             pwm_mask;
  logic [LED_W-1:0] led_q;

  led_pwm_gen u_pwm (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .duty      (bus.duty),
    .mask      (pwm_mask)
  );

  // LEDs stay dark out of reset until the first PWM compare is registered.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      led_q <= '0;
    end else begin
      led_q <= led_state & {LED_W{pwm_mask}};
    end
  end

  assign bus.led_out = led_q;
`else
  assign bus.led_out = led_state;
`endif

endmodule : led_seq

// File: tb/tb_led_seq.sv
// ---------------------------------------------------------------------------
// tb_led_seq
// Self-checking bench for led_seq in its default build (LED_SEQ_DIM_EN
// undefined). The reference model describes each mode as a phase index
// running around the mode's period; the expected LED pattern is derived
// from that phase. Directed scenarios are followed by a randomized run.
// ---------------------------------------------------------------------------
module tb_led_seq;

  localparam int W = 4;

  logic sys_clk = 1'b0;
  logic sys_rst_n;

  always #5 sys_clk = ~sys_clk;

  led_seq_if #(.LED_W(W)) bus ();

  led_seq #(.LED_W(W)) dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .bus       (bus)
  );

  int total = 0;
  int bad   = 0;

  int         m_mode;
  int         m_phase;
  logic [W-1:0] exp_led;
  logic       exp_wrap;

  // Number of steps before each mode repeats.
  function automatic int period_of(int m);
    case (m)
      0, 1:    return W;
      2:       return 2 * (W - 1);
      default: return 2;
    endcase
  endfunction

  // LED pattern for a given mode and phase (phase 0 = start value).
  function automatic logic [W-1:0] pattern_of(int m, int ph);
    logic [W-1:0] one;
    one = 1;
    case (m)
      0:       return one << ph;
      1:       return one << (W - 1 - ph);
      2:       return (ph < W) ? (one << ph) : (one << (2 * (W - 1) - ph));
      default: return (ph == 0) ? {W{1'b1}} : {W{1'b0}};
    endcase
  endfunction

  task automatic model_reset();
    m_mode   = 0;
    m_phase  = 0;
    exp_led  = pattern_of(0, 0);
    exp_wrap = 1'b0;
  endtask

  // Model of one clock edge given the inputs applied before it.
  task automatic model_edge(logic t, logic r, logic [1:0] md);
    if (int'(md) != m_mode) begin
      m_mode   = int'(md);
      m_phase  = 0;
      exp_wrap = 1'b0;
    end else if (r && t) begin
      m_phase  = (m_phase + 1) % period_of(m_mode);
      exp_wrap = (m_phase == 0);
    end else begin
      exp_wrap = 1'b0;
    end
    exp_led = pattern_of(m_mode, m_phase);
  endtask

  task automatic checkOutput(string tag);
    total++;
    assert (bus.led_out === exp_led) else begin
      bad++;
      $error("[TB] FAIL %s led_out got=%b exp=%b", tag, bus.led_out, exp_led);
    end
    total++;
    assert (bus.wrap_out === exp_wrap) else begin
      bad++;
      $error("[TB] FAIL %s wrap_out got=%b exp=%b", tag, bus.wrap_out, exp_wrap);
    end
  endtask

  task automatic checkValue(string tag, logic [W-1:0] led_req, logic wrap_req);
    total++;
    assert (bus.led_out === led_req) else begin
      bad++;
      $error("[TB] FAIL %s led_out got=%b exp=%b", tag, bus.led_out, led_req);
    end
    total++;
    assert (bus.wrap_out === wrap_req) else begin
      bad++;
      $error("[TB] FAIL %s wrap_out got=%b exp=%b", tag, bus.wrap_out, wrap_req);
    end
  endtask

  // Called at a negedge: drive inputs, let one posedge happen, check
  // shortly after it, and return at the following negedge.
  task automatic applyStimulus(string tag, logic t, logic r, logic [1:0] md);
    bus.tick_in = t;
    bus.run     = r;
    bus.mode    = md;
    model_edge(t, r, md);
    @(posedge sys_clk);
    #1;
    checkOutput(tag);
    @(negedge sys_clk);
  endtask

  initial begin
    logic [1:0] cur_mode;
    logic       rt;
    logic       rr;

    sys_rst_n   = 1'b0;
    bus.tick_in = 1'b0;
    bus.run     = 1'b0;
    bus.mode    = 2'd0;
    model_reset();
    #12;
    checkValue("reset", 4'b0001, 1'b0);
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    $display("[TB] rotate-left");

    for (int i = 1; i <= 5; i++) begin
      applyStimulus("rotl_tick", 1'b1, 1'b1, 2'd0);
      if (i == 1) checkValue("rotl_t1", 4'b0010, 1'b0);
      if (i == 4) checkValue("rotl_t4", 4'b0001, 1'b1);
      if (i == 5) checkValue("rotl_t5", 4'b0010, 1'b0);
      applyStimulus("rotl_idle", 1'b0, 1'b1, 2'd0);
    end

    $display("[TB] ping-pong");
    applyStimulus("ping_load", 1'b0, 1'b1, 2'd2);
    checkValue("ping_start", 4'b0001, 1'b0);
    for (int i = 1; i <= 7; i++) begin
      applyStimulus("ping_tick", 1'b1, 1'b1, 2'd2);
      if (i == 3) checkValue("ping_t3", 4'b1000, 1'b0);
      if (i == 4) checkValue("ping_t4", 4'b0100, 1'b0);
      if (i == 6) checkValue("ping_t6", 4'b0001, 1'b1);
      if (i == 7) checkValue("ping_t7", 4'b0010, 1'b0);
    end

    $display("[TB] mode change with tick");
    applyStimulus("to_rotl", 1'b0, 1'b1, 2'd0);
    applyStimulus("chg_tick", 1'b1, 1'b1, 2'd3);
    checkValue("blink_start", 4'b1111, 1'b0);
    applyStimulus("blink_t1", 1'b1, 1'b1, 2'd3);
    checkValue("blink_off", 4'b0000, 1'b0);
    applyStimulus("blink_t2", 1'b1, 1'b1, 2'd3);
    checkValue("blink_wrap", 4'b1111, 1'b1);

    $display("[TB] run low");
    applyStimulus("rotr_load", 1'b0, 1'b1, 2'd1);
    for (int i = 0; i < 10; i++) begin
      applyStimulus("hold_tick", 1'b1, 1'b0, 2'd1);
    end
    checkValue("hold_end", 4'b1000, 1'b0);
    applyStimulus("rotr_step", 1'b1, 1'b1, 2'd1);
    checkValue("rotr_t1", 4'b0100, 1'b0);

    $display("[TB] reset mid ping-pong");
    applyStimulus("ping_load2", 1'b0, 1'b1, 2'd2);
    for (int i = 0; i < 4; i++) begin
      applyStimulus("ping_pre", 1'b1, 1'b1, 2'd2);
    end
    checkValue("ping_mid", 4'b0100, 1'b0);
    bus.tick_in = 1'b0;
    bus.mode    = 2'd0;
    #2;
    sys_rst_n = 1'b0;
    #1;
    model_reset();
    checkValue("async_rst", 4'b0001, 1'b0);
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    applyStimulus("post_rst_idle", 1'b0, 1'b1, 2'd0);
    applyStimulus("post_rst_tick", 1'b1, 1'b1, 2'd0);
    checkValue("post_rst_rotl", 4'b0010, 1'b0);

    $display("[TB] random");
    cur_mode = 2'd0;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 11) == 0) cur_mode = 2'($urandom_range(0, 3));
      rt = 1'($urandom_range(0, 1));
      rr = ($urandom_range(0, 7) != 0);
      applyStimulus("random", rt, rr, cur_mode);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_led_seq
